uart_tx: RTL and testbench
==========================

# uart_tx

UART transmitter: serializes parallel words from an upstream producer onto the `txif.sig` line as 8N1-style frames (start bit, DATA_WIDTH data bits LSB first, one stop bit). It is the transmit-side counterpart of `uart_rx` and shares the same `uart_if` interface and parameter set, so `txif.sig` loops straight into a `uart_rx` instance. A one-word holding buffer allows back-to-back frames with no idle gap between stop bit and next start bit.

## Interface
- DATA_WIDTH, 8, data bits per frame
- BAUD_RATE, 9600, line rate in bits/s
- CLK_FREQ, 100_000_000, clk frequency in Hz
- clk  input  1  system clock, all state on rising edge
- rstn  input  1  asynchronous, active-low reset
- txif  uart_if  —  txif.data (in, DATA_WIDTH) word to send; txif.valid (in, 1) producer has a word; txif.ready (out, 1) block can accept a word; txif.sig (out, 1) serial line, idle high

## Operation
- PULSE_WIDTH = CLK_FREQ / BAUD_RATE (integer division; 10416 at defaults); every bit, start and stop included, lasts exactly PULSE_WIDTH clk cycles.
- Baud counter width $clog2(PULSE_WIDTH); bit counter width $clog2(DATA_WIDTH+1); counters wrap to 0 at each bit boundary, never free-run.
- Transfer occurs on a rising edge where txif.valid && txif.ready; txif.data sampled at that edge only.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: sig=1. On transfer with buffer empty: load shift register directly, go START.
  - START: sig=0 for PULSE_WIDTH cycles, then DATA with bit index 0.
  - DATA: sig=shift[0]; after PULSE_WIDTH cycles shift right, index+1; after bit DATA_WIDTH-1 go STOP.
  - STOP: sig=1 for PULSE_WIDTH cycles. On last cycle: buffer full -> load shift from buffer, clear buffer, go START; else transfer this edge -> load shift from txif.data, go START; else IDLE.
- Holding buffer: a transfer while FSM not in IDLE writes the buffer; txif.ready = !buffer_full, deasserted from the edge after the buffer fills until the edge that drains it.
- Buffer never written and drained at the same edge (ready low while full), so no simultaneous-event conflict.
- Producer may hold valid high with ready low; data must stay stable, no word dropped or duplicated.

## Timing
- Reset (rstn low, async): sig=1, ready=0, FSM IDLE, buffer empty, counters 0, shift register 0.
- First rising edge after rstn release: ready=1.
- Latency: transfer at edge N in IDLE -> sig low from edge N; start bit occupies cycles N..N+PULSE_WIDTH-1.
- Frame length (DATA_WIDTH+2)*PULSE_WIDTH cycles (10*10416 = 104160 at defaults).
- Back-to-back: second word accepted at edge N+1 into buffer; ready low until stop bit of frame 1 ends; frame 2 start bit begins exactly at the edge ending frame 1 stop bit (zero idle cycles).
- sig is registered; no combinational path from txif.valid/data to sig or ready.
- Reset mid-frame: sig returns high immediately, frame and buffered word discarded, no partial-frame resumption after release.

## Test plan
- Reset: hold rstn low 100 cycles -> sig=1, ready=0 throughout; ready=1 one edge after release, sig stays 1 with valid low.
- Single word 0xA5: one-cycle valid -> sig: 0, then 1,0,1,0,0,1,0,1 (LSB first), then 1, each exactly 10416 cycles; ready stays 1.
- Back-to-back 0x00 then 0xFF, valid held high -> second accepted one edge later, ready low ~104159 cycles, frames contiguous, total 208320 cycles, no extra idle.
- Loopback into uart_rx (same parameters): send 0x00..0xFF, random 0..PULSE_WIDTH gaps -> every received word equals sent, order preserved, none lost.
- Backpressure: valid held with 0x3C while ready low -> 0x3C transmitted exactly once after current frame.
- Reset mid-DATA of 0x5A, then send 0x81 -> sig high during reset, next frame is clean 0x81, no 0x5A remnant.

Source files
------------

// File: rtl/uart_tx_if.sv
// Shared serial-link interface between uart_tx and uart_rx.
// The producer side drives data/valid; the transmitter drives ready/sig.
interface uart_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  ready;
    logic                  sig;

    modport tx (input data, input valid, output ready, output sig);
    modport rx (output data, output valid, input ready, input sig);
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, one stop bit.
// A one-word holding buffer lets frames run back-to-back with no idle gap.
module uart_tx #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned BAUD_RATE  = 9600,
    parameter int unsigned CLK_FREQ   = 100_000_000
) (
    input logic clk,
    input logic rstn,
    uart_if.tx  txif
);
    localparam int unsigned PulseWidth = CLK_FREQ / BAUD_RATE;
    localparam int unsigned BaudW      = (PulseWidth > 1) ? $clog2(PulseWidth) : 1;
    localparam int unsigned BitW       = $clog2(DATA_WIDTH + 1);
    localparam logic [BaudW-1:0] BaudLast = BaudW'(PulseWidth - 1);
    localparam logic [BitW-1:0]  BitLast  = BitW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e                state_q, state_d;
    logic [BaudW-1:0]      baud_q, baud_d;
    logic [BitW-1:0]       bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] buf_q, buf_d;
    logic                  buf_full_q, buf_full_d;
    logic                  sig_q, sig_d;
    logic                  ready_q, ready_d;

    logic xfer;
    logic baud_last;
    logic load_direct;

    assign xfer      = txif.valid && ready_q;
    assign baud_last = (baud_q == BaudLast);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= StIdle;
            baud_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            sig_q      <= 1'b1;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            sig_q      <= sig_d;
            ready_q    <= ready_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        baud_d      = baud_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        buf_d       = buf_q;
        buf_full_d  = buf_full_q;
        load_direct = 1'b0;

        unique case (state_q)
            StIdle: begin
                baud_d = '0;
                bit_d  = '0;
                if (xfer) begin
                    shift_d     = txif.data;
                    load_direct = 1'b1;
                    state_d     = StStart;
                end
            end
            StStart: begin
                if (baud_last) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = StData;
                end else begin
                    baud_d = baud_q + BaudW'(1);
                end
            end
            StData: begin
                if (baud_last) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == BitLast) begin
                        bit_d   = '0;
                        state_d = StStop;
                    end else begin
                        bit_d = bit_q + BitW'(1);
                    end
                end else begin
                    baud_d = baud_q + BaudW'(1);
                end
            end
            StStop: begin
                if (baud_last) begin
                    baud_d = '0;
                    // A buffered word always wins; ready is low then, so xfer cannot collide.
                    if (buf_full_q) begin
                        shift_d    = buf_q;
                        buf_full_d = 1'b0;
                        state_d    = StStart;
                    end else if (xfer) begin
                        shift_d     = txif.data;
                        load_direct = 1'b1;
                        state_d     = StStart;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    baud_d = baud_q + BaudW'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        if (xfer && !load_direct) begin
            buf_d      = txif.data;
            buf_full_d = 1'b1;
        end
    end

    // Outputs are registered from next-state values so sig tracks the FSM with no lag.
    always_comb begin
        ready_d = !buf_full_d;
        unique case (state_d)
            StStart: sig_d = 1'b0;
            StData:  sig_d = shift_d[0];
            default: sig_d = 1'b1;
        endcase
    end

    assign txif.ready = ready_q;
    assign txif.sig   = sig_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: per-cycle line model, a mid-bit frame decoder and literal timing pins.
module tb_uart_tx;
    localparam int unsigned DW    = 8;
    localparam int unsigned CLK_F = 700;
    localparam int unsigned BAUD  = 100;
    localparam int          PW    = CLK_F / BAUD;
    localparam int          FRAME = (DW + 2) * PW;

    logic clk;
    logic rstn;
    int   cyc;
    int   checks;
    int   errors;

    uart_if #(.DATA_WIDTH(DW)) txif ();

    uart_tx #(
        .DATA_WIDTH(DW),
        .BAUD_RATE (BAUD),
        .CLK_FREQ  (CLK_F)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .txif(txif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Model: the line is a queue of per-cycle levels; a whole frame is queued when it starts.
    bit          line_q[$];
    logic [7:0]  exp_words[$];
    logic [7:0]  m_buf;
    bit          m_full;
    logic        m_ready;
    logic        m_sig;
    int          rst_count;

    function automatic void push_frame(input logic [7:0] w);
        for (int i = 0; i < PW; i++) line_q.push_back(1'b0);
        for (int b = 0; b < DW; b++)
            for (int i = 0; i < PW; i++) line_q.push_back(w[b]);
        for (int i = 0; i < PW; i++) line_q.push_back(1'b1);
        exp_words.push_back(w);
    endfunction

    initial begin
        bit xfer;
        m_full = 0; m_ready = 1'b0; m_sig = 1'b1; m_buf = '0; rst_count = 0;
        forever begin
            @(posedge clk or negedge rstn);
            if (rstn !== 1'b1) begin
                line_q.delete();
                exp_words.delete();
                m_full  = 0;
                m_ready = 1'b0;
                rst_count++;
            end else begin
                xfer = txif.valid && m_ready;
                if (line_q.size() > 0) void'(line_q.pop_front());
                if (line_q.size() == 0 && m_full) begin
                    push_frame(m_buf);
                    m_full = 0;
                end else if (xfer) begin
                    if (line_q.size() == 0) push_frame(txif.data);
                    else begin
                        m_buf  = txif.data;
                        m_full = 1;
                    end
                end
                m_ready = !m_full;
            end
            m_sig = (line_q.size() > 0) ? line_q[0] : 1'b1;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check("sig_vs_model", {31'd0, txif.sig}, {31'd0, m_sig});
            check("ready_vs_model", {31'd0, txif.ready}, {31'd0, m_ready});
        end
    end

    // Decoder: samples mid-bit, aborts on any reset, checks words in order against the model.
    int rx_cnt;
    initial begin
        int         rc0;
        bit         ok;
        logic [9:0] fr;
        logic [7:0] w;
        rx_cnt = 0;
        forever begin
            @(negedge clk);
            if (rstn === 1'b1 && txif.sig === 1'b0) begin
                rc0 = rst_count;
                ok  = 1;
                fr  = '0;
                for (int c = 1; c <= PW / 2 + 9 * PW; c++) begin
                    @(negedge clk);
                    if (rstn !== 1'b1 || rst_count != rc0) begin
                        ok = 0;
                        break;
                    end
                    if (c >= PW / 2 && (c - PW / 2) % PW == 0) fr[(c - PW / 2) / PW] = txif.sig;
                end
                if (ok) begin
                    check("rx_start_bit", {31'd0, fr[0]}, 32'd0);
                    check("rx_stop_bit", {31'd0, fr[9]}, 32'd1);
                    w = fr[8:1];
                    if (exp_words.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rx_unexpected_word: got %0h expected none", w);
                    end else begin
                        check("rx_word", {24'd0, w}, {24'd0, exp_words.pop_front()});
                    end
                    rx_cnt++;
                end
            end
        end
    end

    task automatic send(input logic [7:0] d, output int t_acc);
        int n;
        txif.valid = 1'b1;
        txif.data  = d;
        n = 0;
        while (!m_ready && n < 30 * PW) begin
            @(posedge clk); #1;
            n++;
        end
        if (!m_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: ready never seen for %0h", d);
        end
        t_acc = cyc + 1;
        @(posedge clk); #1;
        txif.valid = 1'b0;
    endtask

    task automatic goto(input int t);
        while (cyc < t) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         t1, t2, t3, t4;
        int         low;
        logic [9:0] a5_bits;
        checks = 0;
        errors = 0;
        txif.valid = 1'b0;
        txif.data  = '0;
        rstn = 1'b1;
        #1 rstn = 1'b0;

        repeat (100) @(posedge clk);
        #1;
        check("ready_in_reset", {31'd0, txif.ready}, 32'd0);
        rstn = 1'b1;
        #1 check("ready_before_first_edge", {31'd0, txif.ready}, 32'd0);
        @(posedge clk); #1;
        check("ready_after_release", {31'd0, txif.ready}, 32'd1);
        check("sig_idle_after_release", {31'd0, txif.sig}, 32'd1);
        repeat (3) begin @(posedge clk); #1; end

        // Single word 0xA5
        a5_bits = {1'b1, 8'hA5, 1'b0};
        send(8'hA5, t1);
        for (int k = 0; k < 10; k++) begin
            goto(t1 + k * PW + PW / 2);
            check("a5_bit", {31'd0, txif.sig}, {31'd0, a5_bits[k]});
        end
        check("a5_ready_mid_frame", {31'd0, txif.ready}, 32'd1);
        goto(t1 + FRAME - 1);
        check("a5_stop_last_cycle", {31'd0, txif.sig}, 32'd1);
        goto(t1 + FRAME + 3);

        // Back-to-back 0x00 then 0xFF
        send(8'h00, t1);
        send(8'hFF, t2);
        check("b2b_second_accept", t2, t1 + 1);
        low = 0;
        for (int c = t1 + 1; c <= t1 + 2 * FRAME + 2; c++) begin
            goto(c);
            if (txif.ready === 1'b0) low++;
            if (c == t1 + PW + PW / 2)    check("b2b_00_bit0", {31'd0, txif.sig}, 32'd0);
            if (c == t1 + FRAME - 1)      check("b2b_stop1_end", {31'd0, txif.sig}, 32'd1);
            if (c == t1 + FRAME - 1)      check("b2b_ready_low_end", {31'd0, txif.ready}, 32'd0);
            if (c == t1 + FRAME)          check("b2b_start2_first", {31'd0, txif.sig}, 32'd0);
            if (c == t1 + FRAME)          check("b2b_ready_back", {31'd0, txif.ready}, 32'd1);
            if (c == t1 + FRAME + PW + PW / 2) check("b2b_ff_bit0", {31'd0, txif.sig}, 32'd1);
            if (c == t1 + 2 * FRAME)      check("b2b_idle_after", {31'd0, txif.sig}, 32'd1);
        end
        check("b2b_ready_low_cycles", low, FRAME - 1);

        // Backpressure: 0x3C held while the buffer is full
        send(8'h11, t1);
        send(8'h22, t2);
        send(8'h3C, t3);
        check("bp_accept_at_drain", t3, t1 + FRAME + 1);
        goto(t1 + 2 * FRAME + PW + PW / 2);
        check("bp_3c_bit0", {31'd0, txif.sig}, 32'd0);
        goto(t1 + 2 * FRAME + 3 * PW + PW / 2);
        check("bp_3c_bit2", {31'd0, txif.sig}, 32'd1);
        goto(t1 + 3 * FRAME + 3);

        // Reset in the middle of the data bits of 0x5A
        send(8'h5A, t4);
        goto(t4 + 3 * PW + 2);
        @(posedge clk); #1;
        rstn = 1'b0;
        #1;
        check("midrst_sig_high", {31'd0, txif.sig}, 32'd1);
        check("midrst_ready_low", {31'd0, txif.ready}, 32'd0);
        repeat (5) @(posedge clk);
        #1 rstn = 1'b1;
        send(8'h81, t4);
        goto(t4 + PW + PW / 2);
        check("post_rst_81_bit0", {31'd0, txif.sig}, 32'd1);
        goto(t4 + 2 * PW + PW / 2);
        check("post_rst_81_bit1", {31'd0, txif.sig}, 32'd0);
        goto(t4 + FRAME + 2);

        // Sweep every byte value with random gaps
        for (int w = 0; w < 256; w++) begin
            send(8'(w), t1);
            repeat ($urandom_range(0, PW)) begin @(posedge clk); #1; end
        end
        repeat (3 * FRAME) begin @(posedge clk); #1; end

        check("rx_word_count", rx_cnt, 263);
        check("rx_none_pending", exp_words.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
